// File: rtl/bitwise_combiner_pkg.sv
// bitwise_combiner_pkg: shared op encoding and sizing constants for bitwise_combiner
package bitwise_combiner_pkg;
  typedef enum logic [1:0] {OP_AND, OP_OR, OP_XOR, OP_NAND} op_e;
  localparam int FIFO_DEPTH = 2;
  localparam int COUNT_W = 16;
endpackage

// File: rtl/combiner_skid_fifo.sv
// combiner_skid_fifo: 2-entry valid/ready FIFO holding head and tail registers
// Ports: clk, rst_n (async active-low); push_valid/push_ready/push_data in;
//        pop_valid/pop_ready/pop_data out (pop_data is the head entry).
// push_ready depends only on fill, so a pop never opens room for a same-cycle push.
module combiner_skid_fifo
  import bitwise_combiner_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);
  logic [1:0] fill;
  logic [W-1:0] head, tail;
  logic push, pop;
  assign push_ready = fill < 2'(FIFO_DEPTH);
  assign pop_valid = fill != 2'd0;
  assign pop_data = head;
  assign push = push_valid && push_ready;
  assign pop = pop_valid && pop_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill <= 2'd0;
      head <= '0;
      tail <= '0;
    end else begin
      if (push && (fill == 2'd0 || (fill == 2'd1 && pop))) head <= push_data;
      else if (pop && fill == 2'd2) head <= tail;
      if (push && fill == 2'd1 && !pop) tail <= push_data;
      fill <= fill + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/bitwise_combiner.sv
// bitwise_combiner: registered multi-lane AND/OR/XOR/NAND reduction with 2-entry output buffer
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_data/in_op operand side;
//        out_valid/out_ready/out_data result side; out_count counts output handshakes;
//        out_parity (even parity of out_data) only when BITWISE_COMBINER_PARITY_EN is defined.
module bitwise_combiner
  import bitwise_combiner_pkg::*;
#(
  parameter int NUM_IN = 2,
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [1:0]              in_op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [COUNT_W-1:0]      out_count
`ifdef BITWISE_COMBINER_PARITY_EN
  ,
  output logic                    out_parity
`endif
);
  logic [WIDTH-1:0] r_and, r_or, r_xor, res;
  op_e op;
  assign op = op_e'(in_op);
  always_comb begin
    r_and = '1;
    r_or = '0;
    r_xor = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      r_and = r_and & in_data[i*WIDTH +: WIDTH];
      r_or = r_or | in_data[i*WIDTH +: WIDTH];
      r_xor = r_xor ^ in_data[i*WIDTH +: WIDTH];
    end
  end
  assign res = op == OP_AND ? r_and : op == OP_OR ? r_or : op == OP_XOR ? r_xor : ~r_and;
`ifdef BITWISE_COMBINER_PARITY_EN
  // Parity rides in the FIFO entry so it always matches the head word.
  logic [WIDTH:0] head;
  combiner_skid_fifo #(.W(WIDTH + 1)) u_fifo (
    .clk(clk), .rst_n(rst_n),
    .push_valid(in_valid), .push_ready(in_ready), .push_data({^res, res}),
    .pop_valid(out_valid), .pop_ready(out_ready), .pop_data(head)
  );
  assign out_data = head[WIDTH-1:0];
  assign out_parity = head[WIDTH];
`else
  combiner_skid_fifo #(.W(WIDTH)) u_fifo (
    .clk(clk), .rst_n(rst_n),
    .push_valid(in_valid), .push_ready(in_ready), .push_data(res),
    .pop_valid(out_valid), .pop_ready(out_ready), .pop_data(out_data)
  );
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_count <= '0;
    else if (out_valid && out_ready) out_count <= out_count + 1'b1;
  end
endmodule

// File: tb/tb_bitwise_combiner.sv
// tb_bitwise_combiner: randomized and directed checks of bitwise_combiner against a queue model
module tb_bitwise_combiner;
  localparam int N = 3;
  localparam int W = 8;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [N*W-1:0] in_data = '0;
  logic [1:0] in_op = 2'd0;
  logic [W-1:0] out_data;
  logic [15:0] out_count;
`ifdef BITWISE_COMBINER_PARITY_EN
  logic out_parity;
`endif
  int checks = 0, errors = 0;
  logic [W-1:0] q[$];
  logic [15:0] mcnt = 0;

  bitwise_combiner #(.NUM_IN(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_op(in_op), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count)
`ifdef BITWISE_COMBINER_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  // Per bit: count the ones across lanes and apply the op's truth rule.
  function automatic logic [W-1:0] ref_red(logic [N*W-1:0] d, int op);
    logic [W-1:0] r;
    for (int b = 0; b < W; b++) begin
      int n = 0;
      for (int l = 0; l < N; l++) n += int'(d[l*W+b]);
      r[b] = op == 0 ? (n == N) : op == 1 ? (n > 0) : op == 2 ? (n % 2 == 1) : (n != N);
    end
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    bit pu, po;
    if (!rst_n) begin
      q.delete();
      mcnt = 0;
    end else begin
      pu = in_valid && q.size() < 2;
      po = q.size() != 0 && out_ready;
      if (po) begin
        void'(q.pop_front());
        mcnt++;
      end
      if (pu) q.push_back(ref_red(in_data, int'(in_op)));
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
      chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
      chk("out_count", {16'd0, out_count}, {16'd0, mcnt});
      if (q.size() != 0) chk("out_data", {24'd0, out_data}, {24'd0, q[0]});
`ifdef BITWISE_COMBINER_PARITY_EN
      chk("out_parity", {31'd0, out_parity}, {31'd0, ^out_data});
`endif
    end
  end

  logic [7:0] lit_exp[4] = '{8'h30, 8'hFF, 8'h33, 8'hCF};

  initial begin
    logic [N*W-1:0] lanes;
    lanes = {8'hFF, 8'h3C, 8'hF0};
    for (int o = 0; o < 4; o++) chk("model_lit", {24'd0, ref_red(lanes, o)}, {24'd0, lit_exp[o]});
    step();
    step();
    rst_n = 1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_count", {16'd0, out_count}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    out_ready = 1;
    for (int o = 0; o < 4; o++) begin
      in_valid = 1;
      in_data = lanes;
      in_op = 2'(o);
      step();
      in_valid = 0;
      chk("lit_valid", {31'd0, out_valid}, 32'd1);
      chk("lit_data", {24'd0, out_data}, {24'd0, lit_exp[o]});
`ifdef BITWISE_COMBINER_PARITY_EN
      chk("lit_parity", {31'd0, out_parity}, 32'd0);
`endif
      step();
    end
    in_valid = 1;
    for (int i = 0; i < 20; i++) begin
      in_data = N*W'($urandom);
      in_op = 2'($urandom);
      step();
      chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
    end
    in_valid = 0;
    step();
    out_ready = 0;
    in_valid = 1;
    in_data = lanes;
    in_op = 2'd0;
    step();
    in_op = 2'd1;
    step();
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    in_op = 2'd2;
    step();
    chk("bp_still_full", {31'd0, in_ready}, 32'd0);
    chk("bp_hold_head", {24'd0, out_data}, 32'h30);
    in_valid = 0;
    out_ready = 1;
    step();
    chk("bp_drain2", {24'd0, out_data}, 32'hFF);
    step();
    chk("bp_empty", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 3000; i++) begin
      in_valid = 1'($urandom);
      out_ready = 1'($urandom);
      in_data = N*W'($urandom);
      in_op = 2'($urandom);
      step();
    end
    in_valid = 1;
    out_ready = 1;
    for (int i = 0; i < 70000 && mcnt != 16'hFFFF; i++) begin
      in_data = N*W'($urandom);
      step();
    end
    in_valid = 0;
    out_ready = 0;
    chk("wrap_ffff", {16'd0, out_count}, 32'hFFFF);
    out_ready = 1;
    step();
    chk("wrap_zero", {16'd0, out_count}, 32'h0);
    step();
    out_ready = 0;
    in_valid = 1;
    in_data = lanes;
    in_op = 2'd2;
    step();
    step();
    chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
    #2 rst_n = 0;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_count", {16'd0, out_count}, 32'd0);
    chk("async_rst_data", {24'd0, out_data}, 32'd0);
    step();
    step();
    rst_n = 1;
    in_valid = 0;
    out_ready = 1;
    step();
    chk("post_rst_empty", {31'd0, out_valid}, 32'd0);
    step();
    chk("post_rst_count", {16'd0, out_count}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
